btpipe_out_buffer: RTL and testbench

Block-throttled buffer that sits directly upstream of the block-throttled pipe-out endpoint. It accepts 32-bit words from a streaming data source through a valid/ready handshake and stores them in an internal FIFO. It drives the endpoint's data and ready inputs so the host only starts a block transfer when a full block is buffered. This replaces free-running generators wherever real acquisition data feeds the host.

---
 rtl/btpipe_out_buffer.sv | 134 +++++++++++++
 tb/tb_btpipe_out_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btpipe_out_buffer.sv
// Block-throttled output buffer feeding the block-throttled pipe-out endpoint.
// Words from a valid/ready source go into a FIFO. pipe_out_ready is raised only
// when a whole host block is buffered beyond the burst currently in flight.
module btpipe_out_buffer #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  src_valid,
    input  logic [31:0]           src_data,
    output logic                  src_ready,
    input  logic                  pipe_out_read,
    output logic [31:0]           pipe_out_data,
    output logic                  pipe_out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underflow
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned CW    = DEPTH_LOG2 + 2;
    localparam int unsigned CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    logic [31:0]      mem [0:(1 << DEPTH_LOG2) - 1];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic             empty, full_nxt;
    logic             wr_en, rd_en;
    logic             ready_nxt;
    logic [CW-1:0]    remaining_nxt;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] blk_cnt, blk_cnt_nxt;

    // Flush blocks both sides of the FIFO for the cycle it is high.
    assign empty = (wr_ptr == rd_ptr);
    assign wr_en = src_valid && src_ready && !flush;
    assign rd_en = pipe_out_read && !empty && !flush;
    assign level = wr_ptr - rd_ptr;

    // Next-state pointers and the flags derived from them.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
            if (rd_en) rd_ptr_nxt = rd_ptr + PW'(1);
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt  = (wr_ptr_nxt[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0]) &&
                    (wr_ptr_nxt[DEPTH_LOG2] != rd_ptr_nxt[DEPTH_LOG2]);
    end

    // Block tracker next state; underflowing reads still count toward the block.
    always_comb begin
        state_nxt   = state;
        blk_cnt_nxt = blk_cnt;
        if (flush) begin
            state_nxt   = IDLE;
            blk_cnt_nxt = '0;
        end else if (pipe_out_read) begin
            case (state)
                IDLE: begin
                    state_nxt   = BURST;
                    blk_cnt_nxt = CNT_W'(1);
                end
                BURST: begin
                    if (blk_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
                        state_nxt   = IDLE;
                        blk_cnt_nxt = '0;
                    end else begin
                        blk_cnt_nxt = blk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    blk_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Ready test rearranged as level >= BLOCK_WORDS + remaining to stay unsigned.
    always_comb begin
        remaining_nxt = '0;
        if (state_nxt == BURST) remaining_nxt = CW'(BLOCK_WORDS) - CW'(blk_cnt_nxt);
        ready_nxt = !flush && (CW'(level_nxt) >= (CW'(BLOCK_WORDS) + remaining_nxt));
    end

    // Block tracker state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            blk_cnt <= '0;
        end else begin
            state   <= state_nxt;
            blk_cnt <= blk_cnt_nxt;
        end
    end

    // Pointers, handshake flags, read data and sticky underflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            src_ready      <= 1'b0;
            pipe_out_ready <= 1'b0;
            pipe_out_data  <= '0;
            underflow      <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            src_ready      <= !flush && !full_nxt;
            pipe_out_ready <= ready_nxt;
            if (rd_en) pipe_out_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            if (flush) underflow <= 1'b0;
            else if (pipe_out_read && empty) underflow <= 1'b1;
        end
    end

    // Storage RAM write port (no reset on the array).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= src_data;
    end

endmodule

// File: tb/tb_btpipe_out_buffer.sv
// Directed bench for btpipe_out_buffer (DEPTH_LOG2=4, BLOCK_WORDS=4).
// Read stimulus pushes the expected word; a monitor pops and compares it
// on the falling edge after each accepted read strobe.
module tb_btpipe_out_buffer;

    localparam int unsigned DL = 4;
    localparam int unsigned BW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          src_valid = 1'b0;
    logic [31:0]   src_data = '0;
    logic          src_ready;
    logic          pipe_out_read = 1'b0;
    logic [31:0]   pipe_out_data;
    logic          pipe_out_ready;
    logic [DL:0]   level;
    logic          underflow;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic          rd_seen = 1'b0;

    btpipe_out_buffer #(
        .DEPTH_LOG2 (DL),
        .BLOCK_WORDS(BW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .pipe_out_read (pipe_out_read),
        .pipe_out_data (pipe_out_data),
        .pipe_out_ready(pipe_out_ready),
        .level         (level),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a read strobe sampled at an edge yields data after it.
    always @(posedge clk) rd_seen <= pipe_out_read && reset_n && !flush;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_data: got 0x%08h with no expected word queued", pipe_out_data);
            end else begin
                chk("read_data", pipe_out_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        src_valid = 1'b1;
        src_data  = d;
        cyc();
        src_valid = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] e);
        pipe_out_read = 1'b1;
        exp_q.push_back(e);
        cyc();
        pipe_out_read = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},      pipe_out_data,  32'h0);
        chk({tag, "_ready"},     32'(pipe_out_ready), 32'h0);
        chk({tag, "_src_ready"}, 32'(src_ready), 32'h0);
        chk({tag, "_level"},     32'(level),     32'h0);
        chk({tag, "_underflow"}, 32'(underflow), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while inputs toggle.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_valid     = ~src_valid;
            pipe_out_read = ~pipe_out_read;
            flush         = (i == 1);
            src_data      = 32'hA5A5_0000 + 32'(i);
            cyc();
            chk_all_zero("reset");
        end
        src_valid = 1'b0; pipe_out_read = 1'b0; flush = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("src_ready_before_edge", 32'(src_ready), 32'h0);
        cyc();
        chk("src_ready_after_release", 32'(src_ready), 32'h1);
        chk("level_after_release", 32'(level), 32'h0);

        // Block gating.
        for (int i = 1; i <= 3; i++) write_word(32'(i));
        chk("gate_level3", 32'(level), 32'd3);
        chk("gate_ready3", 32'(pipe_out_ready), 32'h0);
        write_word(32'h4);
        chk("gate_level4", 32'(level), 32'd4);
        chk("gate_ready4", 32'(pipe_out_ready), 32'h1);
        read_word(32'h1);
        chk("gate_ready_in_burst", 32'(pipe_out_ready), 32'h0);
        for (int i = 2; i <= 4; i++) read_word(32'(i));
        chk("gate_level_end", 32'(level), 32'h0);
        chk("gate_ready_end", 32'(pipe_out_ready), 32'h0);

        // Full and wrap.
        for (int i = 0; i < 16; i++) begin
            write_word(32'h100 + 32'(i));
            if (i == 14) chk("full_src_ready15", 32'(src_ready), 32'h1);
        end
        chk("full_level", 32'(level), 32'd16);
        chk("full_src_ready", 32'(src_ready), 32'h0);
        src_valid = 1'b1;
        src_data  = 32'h200;
        cyc();
        cyc();
        chk("held_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            src_data = (i == 0) ? 32'h200 : 32'h200 + 32'(i - 1);
            read_word(32'h100 + 32'(i));
            if (i == 0) begin
                chk("unfull_level", 32'(level), 32'd15);
                chk("unfull_src_ready", 32'(src_ready), 32'h1);
            end
        end
        src_data = 32'h20F;
        cyc();
        src_valid = 1'b0;
        chk("wrap_level16", 32'(level), 32'd16);
        chk("wrap_src_ready", 32'(src_ready), 32'h0);
        for (int i = 0; i < 16; i++) read_word(32'h200 + 32'(i));
        chk("wrap_level_end", 32'(level), 32'h0);

        // Overlap: second block stays ready while the first is in flight.
        for (int i = 0; i < 8; i++) write_word(32'h300 + 32'(i));
        chk("ovl_ready_start", 32'(pipe_out_ready), 32'h1);
        src_valid = 1'b1;
        src_data  = 32'h308;
        read_word(32'h300);
        src_valid = 1'b0;
        chk("ovl_ready_r1", 32'(pipe_out_ready), 32'h1);
        for (int i = 1; i < 4; i++) begin
            read_word(32'h300 + 32'(i));
            chk("ovl_ready_rn", 32'(pipe_out_ready), 32'h1);
        end
        chk("ovl_level", 32'(level), 32'd5);
        for (int i = 4; i < 8; i++) read_word(32'h300 + 32'(i));
        chk("ovl_level_drain", 32'(level), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("ovl_flush_level", 32'(level), 32'h0);
        chk("ovl_flush_src_ready", 32'(src_ready), 32'h0);
        cyc();
        chk("ovl_src_ready_back", 32'(src_ready), 32'h1);

        // Underflow: data holds at the last word read.
        for (int i = 0; i < 4; i++) begin
            read_word(32'h307);
            chk("udf_flag", 32'(underflow), 32'h1);
        end
        chk("udf_level", 32'(level), 32'h0);
        for (int i = 0; i < 4; i++) write_word(32'h400 + 32'(i));
        chk("udf_fsm_idle_ready", 32'(pipe_out_ready), 32'h1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("udf_cleared", 32'(underflow), 32'h0);
        chk("udf_flush_ready", 32'(pipe_out_ready), 32'h0);
        chk("udf_flush_level", 32'(level), 32'h0);
        cyc();

        // Reset in the middle of a burst.
        for (int i = 0; i < 6; i++) write_word(32'h500 + 32'(i));
        read_word(32'h500);
        read_word(32'h501);
        cyc();
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("midrst_src_ready", 32'(src_ready), 32'h1);
        for (int i = 0; i < 4; i++) write_word(32'h600 + 32'(i));
        chk("midrst_fsm_idle_ready", 32'(pipe_out_ready), 32'h1);
        for (int i = 0; i < 4; i++) read_word(32'h600 + 32'(i));
        chk("midrst_level_end", 32'(level), 32'h0);

        // Flush concurrent with a write and a read.
        for (int i = 0; i < 4; i++) write_word(32'h700 + 32'(i));
        flush         = 1'b1;
        src_valid     = 1'b1;
        src_data      = 32'h7FF;
        pipe_out_read = 1'b1;
        cyc();
        flush = 1'b0; src_valid = 1'b0; pipe_out_read = 1'b0;
        chk("flush_level", 32'(level), 32'h0);
        chk("flush_ready", 32'(pipe_out_ready), 32'h0);
        chk("flush_src_ready", 32'(src_ready), 32'h0);
        cyc();
        chk("flush_src_ready_back", 32'(src_ready), 32'h1);
        chk("flush_write_discarded", 32'(level), 32'h0);
        for (int i = 0; i < 4; i++) write_word(32'h800 + 32'(i));
        chk("flush_fsm_idle_ready", 32'(pipe_out_ready), 32'h1);
        for (int i = 0; i < 4; i++) read_word(32'h800 + 32'(i));
        chk("flush_level_end", 32'(level), 32'h0);

        cyc();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
